sales_counter_bank: RTL and testbench
=====================================

Name: sales_counter_bank

Overview:
- Per-slot sales and stock record keeper for the vending machine.
- Converts purchase and restock button events into per-slot two-digit BCD sold counts, stock levels and a machine-wide BCD total.
- Writer side of the sold-count display path: its sold1/sold2 outputs for the selected slot feed the sold-count 7-segment display directly.

Parameters:
- SLOTS, 7, number of slots; valid slot numbers are 1..SLOTS (3-bit, 0 is invalid).
- INIT_STOCK, 10, stock loaded into every slot at reset and on restock (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sale_req  in  1  purchase request level; an event is its rising edge
- sale_slot  in  3  slot being purchased, sampled on the sale_req edge cycle
- restock_req  in  1  restock request level; an event is its rising edge
- restock_slot  in  3  slot being restocked, sampled on the restock_req edge cycle
- clear_all  in  1  level; clears all sold counts and the total
- view_slot  in  3  slot whose counts are presented
- sold1  out  4  BCD units of sold count for view_slot
- sold2  out  4  BCD tens of sold count for view_slot
- stock  out  4  binary stock of view_slot
- total_bcd  out  12  3-digit BCD total sold over all slots ([3:0] units)
- sale_ok  out  1  one-cycle pulse: sale accepted
- sale_rej  out  1  one-cycle pulse: sale refused

Behaviour:
- Reset (rst=1 at a clk edge):
  - all sold counts = 00, all stock = INIT_STOCK, total = 000;
  - sold1 = sold2 = stock = 0, total_bcd = 0, sale_ok = sale_rej = 0.
  - Edge-detect registers reset to 1, so a request held high through reset does not fire.
- Edge detect: event = req & ~req_d; req_d is a registered copy of req. One event per press; holding the level gives no repeats.
- Sale event, slot s:
  - Accepted if 1 <= s <= SLOTS and stock[s] > 0.
  - On acceptance: stock[s] - 1; sold[s] BCD +1, saturating at 99; total BCD +1, saturating at 999.
  - sale_ok pulses the cycle after the event, for exactly 1 cycle.
  - Otherwise: no state change, and sale_rej pulses the cycle after the event.
  - The stock decrement is applied even when sold[s] is already saturated at 99.
- Restock event, slot r: stock[r] = INIT_STOCK; sold counts are untouched. Invalid r is ignored, with no pulse.
- Simultaneous events, same cycle:
  - Sale and restock on the same slot: restock wins and the sale is rejected (sale_rej).
  - Sale and restock on different slots: both are processed.
  - clear_all=1 with a sale event: clear wins, the sale is rejected and stock is unchanged.
- clear_all: sold counts and total go to 0 on the next edge while high. Stock is unaffected. Restock still proceeds.
- Outputs are registered, with 1-cycle latency from any view_slot change or state update.
  - view_slot = 0 or > SLOTS gives sold1 = sold2 = stock = 0.
- BCD rules: digits are always 0..9. Units 9 +1 gives units 0 and tens +1. 99 +1 stays 99; 999 +1 stays 999.
- sale_ok and sale_rej are never high together. They are 0 in every cycle with no sale event.
- Reset mid-operation: any pending pulse is dropped; outputs read 0 on the cycle after rst.

Decomposition:
- Shared package vm_pkg:
  - SLOT_W = 3, BCD_W = 4, SLOT_MIN = 1, SLOT_MAX = 7;
  - sold_t, a 2-digit BCD struct;
  - the INIT_STOCK default.
- Sub-module bcd_sat_inc: an N-digit BCD saturating incrementer, parameterised by digit count. It is instantiated for the per-slot counter (2 digits) and the total (3 digits).
- Storage is a register array indexed by slot. No RAM.

Test Plan:
- Reset, then view_slot=3 -> sold2/sold1=0/0, stock=10, total=000, no pulses.
- Twelve sale edges on slot 3 -> first 10 each give sale_ok; events 11–12 give sale_rej; view 3 shows sold 1/0, stock 0; total=010.
- Preload slot 5 sold=98, then 3 accepted sales (restock between) -> sold 9/9 stays; stock decreases by 3; total +3.
- Same-cycle sale+restock on slot 2 (stock 4) -> sale_rej, stock=10, sold unchanged; repeat on slots 2/6 -> sale_ok on 2, stock6=10.
- sale_slot=0 and sale_slot=7 with SLOTS=6 -> sale_rej, no state change; sale_req held high 20 cycles -> exactly one pulse.
- clear_all asserted with a sale on slot 1 -> all sold=00, total=000, sale_rej, stock1 unchanged; rst while sale_req high -> no event after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared widths, limits and payload types for the vending-machine sales record keeper.
package vm_pkg;
  localparam int unsigned SLOT_W         = 3;
  localparam int unsigned BCD_W          = 4;
  localparam int unsigned SLOT_MIN       = 1;
  localparam int unsigned SLOT_MAX       = 7;
  localparam int unsigned STOCK_W        = 4;
  localparam int unsigned SOLD_DIGITS    = 2;
  localparam int unsigned TOTAL_DIGITS   = 3;
  localparam int unsigned TOTAL_W        = TOTAL_DIGITS * BCD_W;
  localparam int unsigned INIT_STOCK_DEF = 10;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } sold_t;

  // True when s addresses a populated slot (SLOT_MIN..hi).
  function automatic logic slot_in_range(input logic [SLOT_W-1:0] s, input int unsigned hi);
    return (32'(s) >= SLOT_MIN) && (32'(s) <= hi);
  endfunction
endpackage

// File: rtl/sales_counter_bank_if.sv
// Request/view/result bundle between the button front end and the sales record keeper.
interface sales_counter_bank_if;
  import vm_pkg::*;

  logic               sale_req;
  logic [SLOT_W-1:0]  sale_slot;
  logic               restock_req;
  logic [SLOT_W-1:0]  restock_slot;
  logic               clear_all;
  logic [SLOT_W-1:0]  view_slot;
  logic [BCD_W-1:0]   sold1;
  logic [BCD_W-1:0]   sold2;
  logic [STOCK_W-1:0] stock;
  logic [TOTAL_W-1:0] total_bcd;
  logic               sale_ok;
  logic               sale_rej;

  modport master (
    output sale_req, sale_slot, restock_req, restock_slot, clear_all, view_slot,
    input  sold1, sold2, stock, total_bcd, sale_ok, sale_rej
  );

  modport slave (
    input  sale_req, sale_slot, restock_req, restock_slot, clear_all, view_slot,
    output sold1, sold2, stock, total_bcd, sale_ok, sale_rej
  );
endinterface

// File: rtl/bcd_sat_inc.sv
// N-digit BCD incrementer that holds at all-nines instead of wrapping.
module bcd_sat_inc
  import vm_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic [DIGITS*BCD_W-1:0] value_in,
  output logic [DIGITS*BCD_W-1:0] value_inc_c
);
  localparam logic [BCD_W-1:0] NINE = BCD_W'(9);

  logic             carry;
  logic             saturated;
  logic [BCD_W-1:0] digit;

  // Ripple a +1 through the digits, units first.
  always_comb begin
    value_inc_c = value_in;
    carry       = 1'b1;
    saturated   = 1'b1;
    digit       = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value_in[i*BCD_W +: BCD_W] != NINE) saturated = 1'b0;
    end
    if (!saturated) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit = value_in[i*BCD_W +: BCD_W];
        if (carry) begin
          if (digit == NINE) begin
            value_inc_c[i*BCD_W +: BCD_W] = '0;
          end else begin
            value_inc_c[i*BCD_W +: BCD_W] = BCD_W'(digit + BCD_W'(1));
            carry = 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: rtl/sales_counter_bank.sv
// Per-slot BCD sold counts, stock levels and machine-wide BCD total, driven by button edges.
module sales_counter_bank
  import vm_pkg::*;
#(
  parameter int unsigned SLOTS      = SLOT_MAX,
  parameter int unsigned INIT_STOCK = INIT_STOCK_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sales_counter_bank_if.slave  bus
);
  localparam int unsigned        NUM_IDX = 1 << SLOT_W;
  localparam logic [STOCK_W-1:0] INIT_Q  = STOCK_W'(INIT_STOCK);

  logic               sale_req_d;
  logic               restock_req_d;
  logic [STOCK_W-1:0] stock_q [NUM_IDX];
  sold_t              sold_q  [NUM_IDX];
  logic [TOTAL_W-1:0] total_q;

  logic               sale_ev_c;
  logic               restock_ev_c;
  logic               restock_hit_c;
  logic               sale_accept_c;
  sold_t              sold_sel_c;
  sold_t              sold_inc_c;
  logic [TOTAL_W-1:0] total_inc_c;

  assign sale_ev_c     = bus.sale_req & ~sale_req_d;
  assign restock_ev_c  = bus.restock_req & ~restock_req_d;
  assign restock_hit_c = restock_ev_c && slot_in_range(bus.restock_slot, SLOTS);

  // A same-slot restock or a clear in the same cycle pre-empts the sale.
  assign sale_accept_c = sale_ev_c
                      && slot_in_range(bus.sale_slot, SLOTS)
                      && (stock_q[bus.sale_slot] != '0)
                      && !bus.clear_all
                      && !(restock_hit_c && (bus.restock_slot == bus.sale_slot));

  assign sold_sel_c = sold_q[bus.sale_slot];

  bcd_sat_inc #(.DIGITS(SOLD_DIGITS)) u_sold_inc (
    .value_in    (sold_sel_c),
    .value_inc_c (sold_inc_c)
  );

  bcd_sat_inc #(.DIGITS(TOTAL_DIGITS)) u_total_inc (
    .value_in    (total_q),
    .value_inc_c (total_inc_c)
  );

  // Edge detectors start high so a request held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      sale_req_d    <= 1'b1;
      restock_req_d <= 1'b1;
      total_q       <= '0;
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
        stock_q[i] <= slot_in_range(SLOT_W'(i), SLOTS) ? INIT_Q : '0;
        sold_q[i]  <= '0;
      end
    end else begin
      sale_req_d    <= bus.sale_req;
      restock_req_d <= bus.restock_req;
      if (bus.clear_all)  total_q <= '0;
      else if (sale_accept_c) total_q <= total_inc_c;
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
        if (slot_in_range(SLOT_W'(i), SLOTS)) begin
          if (bus.clear_all) begin
            sold_q[i] <= '0;
          end else if (sale_accept_c && (bus.sale_slot == SLOT_W'(i))) begin
            sold_q[i] <= sold_inc_c;
          end
          if (restock_hit_c && (bus.restock_slot == SLOT_W'(i))) begin
            stock_q[i] <= INIT_Q;
          end else if (sale_accept_c && (bus.sale_slot == SLOT_W'(i))) begin
            stock_q[i] <= stock_q[i] - STOCK_W'(1);
          end
        end
      end
    end
  end

  // Registered presentation of the viewed slot, the total and the sale verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sold1     <= '0;
      bus.sold2     <= '0;
      bus.stock     <= '0;
      bus.total_bcd <= '0;
      bus.sale_ok   <= 1'b0;
      bus.sale_rej  <= 1'b0;
    end else begin
      if (slot_in_range(bus.view_slot, SLOTS)) begin
        bus.sold1 <= sold_q[bus.view_slot].units;
        bus.sold2 <= sold_q[bus.view_slot].tens;
        bus.stock <= stock_q[bus.view_slot];
      end else begin
        bus.sold1 <= '0;
        bus.sold2 <= '0;
        bus.stock <= '0;
      end
      bus.total_bcd <= total_q;
      bus.sale_ok   <= sale_accept_c;
      bus.sale_rej  <= sale_ev_c && !sale_accept_c;
    end
  end
endmodule

// File: tb/tb_sales_counter_bank.sv
// Directed plus randomized bench for sales_counter_bank against a decimal reference model.
module tb_sales_counter_bank;
  import vm_pkg::*;

  localparam int unsigned SLOTS = 6;
  localparam int unsigned INIT  = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int   m_sold  [8];
  int   m_stock [8];
  int   m_total;
  logic m_sd;
  logic m_rd;

  always #5 clk = ~clk;

  sales_counter_bank_if bus();

  sales_counter_bank #(.SLOTS(SLOTS), .INIT_STOCK(INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit valid(input int s);
    return (s >= 1) && (s <= int'(SLOTS));
  endfunction

  function automatic logic [11:0] bcd3(input int t);
    return {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic s_req);
    rst = 1'b1;
    bus.sale_req = s_req; bus.sale_slot = 3'd1;
    bus.restock_req = 1'b0; bus.restock_slot = 3'd0;
    bus.clear_all = 1'b0; bus.view_slot = 3'd3;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      m_sold[i]  = 0;
      m_stock[i] = valid(i) ? int'(INIT) : 0;
    end
    m_total = 0; m_sd = 1'b1; m_rd = 1'b1;
    check("rst_sold1", 12'(bus.sold1), 12'd0);
    check("rst_sold2", 12'(bus.sold2), 12'd0);
    check("rst_stock", 12'(bus.stock), 12'd0);
    check("rst_total", bus.total_bcd, 12'd0);
    check("rst_ok",    12'(bus.sale_ok), 12'd0);
    check("rst_rej",   12'(bus.sale_rej), 12'd0);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic cyc(input logic s_req, input int s_slot, input logic r_req, input int r_slot,
                     input logic clr, input int v);
    logic [11:0] e_s1, e_s2, e_st, e_tot;
    bit sev, rev, acc;
    bus.sale_req = s_req;    bus.sale_slot = 3'(s_slot);
    bus.restock_req = r_req; bus.restock_slot = 3'(r_slot);
    bus.clear_all = clr;     bus.view_slot = 3'(v);
    e_s1  = valid(v) ? 12'(m_sold[v] % 10) : 12'd0;
    e_s2  = valid(v) ? 12'(m_sold[v] / 10) : 12'd0;
    e_st  = valid(v) ? 12'(m_stock[v]) : 12'd0;
    e_tot = bcd3(m_total);
    sev = s_req && !m_sd;
    rev = r_req && !m_rd;
    acc = sev && valid(s_slot) && (m_stock[s_slot] > 0) && !clr && !(rev && r_slot == s_slot);
    if (clr) begin
      for (int i = 0; i < 8; i++) m_sold[i] = 0;
      m_total = 0;
    end
    if (acc) begin
      m_stock[s_slot]--;
      if (m_sold[s_slot] < 99) m_sold[s_slot]++;
      if (m_total < 999) m_total++;
    end
    if (rev && valid(r_slot)) m_stock[r_slot] = int'(INIT);
    m_sd = s_req; m_rd = r_req;
    @(posedge clk); #1;
    check("sale_ok",  12'(bus.sale_ok),  12'(acc));
    check("sale_rej", 12'(bus.sale_rej), 12'(sev && !acc));
    check("sold1",    12'(bus.sold1), e_s1);
    check("sold2",    12'(bus.sold2), e_s2);
    check("stock",    12'(bus.stock), e_st);
    check("total",    bus.total_bcd, e_tot);
  endtask

  task automatic press_sale(input int s, input int v);
    cyc(1'b1, s, 1'b0, 0, 1'b0, v);
    cyc(1'b0, s, 1'b0, 0, 1'b0, v);
  endtask

  task automatic press_restock(input int r, input int v);
    cyc(1'b0, 0, 1'b1, r, 1'b0, v);
    cyc(1'b0, 0, 1'b0, r, 1'b0, v);
  endtask

  initial begin
    int oks;
    do_reset(1'b0);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 3);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 3);
    check("init_stock3", 12'(bus.stock), 12'd10);

    // Drain slot 3 past empty.
    for (int k = 0; k < 12; k++) press_sale(3, 3);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 3);
    check("s3_sold2", 12'(bus.sold2), 12'd1);
    check("s3_sold1", 12'(bus.sold1), 12'd0);
    check("s3_stock", 12'(bus.stock), 12'd0);
    check("s3_total", bus.total_bcd, 12'h010);

    // Bring slot 5 to 98 sold, then saturate.
    while (m_sold[5] < 98) begin
      if (m_stock[5] == 0) press_restock(5, 5);
      press_sale(5, 5);
    end
    press_restock(5, 5);
    for (int k = 0; k < 3; k++) press_sale(5, 5);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 5);
    check("s5_sold2", 12'(bus.sold2), 12'd9);
    check("s5_sold1", 12'(bus.sold1), 12'd9);
    check("s5_stock", 12'(bus.stock), 12'd7);

    // Same-cycle sale and restock.
    press_restock(2, 2);
    for (int k = 0; k < 6; k++) press_sale(2, 2);
    cyc(1'b1, 2, 1'b1, 2, 1'b0, 2);
    check("same_rej", 12'(bus.sale_rej), 12'd1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 2);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 2);
    check("same_stock", 12'(bus.stock), 12'd10);
    press_sale(6, 6);
    cyc(1'b1, 2, 1'b1, 6, 1'b0, 6);
    check("diff_ok", 12'(bus.sale_ok), 12'd1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 6);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 6);
    check("diff_stock6", 12'(bus.stock), 12'd10);

    // Invalid slots, out-of-range view, and a held request.
    press_sale(0, 7);
    press_sale(7, 0);
    oks = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1, 1'b0, 0, 1'b0, 1);
      oks += int'(bus.sale_ok);
    end
    cyc(1'b0, 1, 1'b0, 0, 1'b0, 1);
    check("held_one_pulse", 12'(oks), 12'd1);

    // Clear with a sale in the same cycle.
    cyc(1'b1, 1, 1'b0, 0, 1'b1, 1);
    check("clr_rej", 12'(bus.sale_rej), 12'd1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1);
    check("clr_total", bus.total_bcd, 12'h000);
    check("clr_stock1", 12'(bus.stock), 12'd9);

    // Reset while a request is held high.
    cyc(1'b1, 4, 1'b0, 0, 1'b0, 4);
    do_reset(1'b1);
    cyc(1'b1, 4, 1'b0, 0, 1'b0, 4);
    check("rst_hold_no_ok", 12'(bus.sale_ok | bus.sale_rej), 12'd0);
    cyc(1'b0, 4, 1'b0, 0, 1'b0, 4);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 31) == 0), int'($urandom_range(0, 7)));
    end

    // Drive the total to saturation.
    do_reset(1'b0);
    for (int k = 0; m_total < 999; k++) begin
      if (m_stock[(k % 6) + 1] == 0) press_restock((k % 6) + 1, (k % 6) + 1);
      press_sale((k % 6) + 1, (k % 6) + 1);
    end
    press_restock(1, 1);
    for (int k = 0; k < 3; k++) press_sale(1, 1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1);
    check("total_sat", bus.total_bcd, 12'h999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
